i2c_rx_fifo_receiver: RTL and testbench

Single-clock I2C byte receiver: oversamples `SCL_in`/`SDA_in` on `clk`, shifts `DATA_WIDTH`-bit frames MSB-first, drives the ACK/NACK bit, and buffers received bytes in a `FIFO_DEPTH`-entry FIFO drained by the controller through a valid/ready handshake. It sits between the bus pad logic and the I2C controller/pattern detector. It supports multi-byte bursts without controller service between bytes.

---
 rtl/i2c_rx_fifo_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_rx_fifo_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_fifo_receiver.sv
// I2C byte receiver: oversampled SCL/SDA, MSB-first shift, ACK/NACK drive,
// and a FIFO_DEPTH-entry receive FIFO drained through valid/ready.
//
// Optional feature macro: I2C_RX_SYNC_EN adds two-flop input synchronizers.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   read_enable_pattern_detector  : target-mode receive, drives ACK/NACK
//   read_enable_controller        : controller-mode receive, SDA_out held 1
//   SCL_in, SDA_in                : bus levels
//   error                         : force NACK on the byte in its ACK slot
//   SDA_out                       : open-drain data drive (0 = pull low)
//   controller_data_rsp           : FIFO head (0 when empty)
//   rsp_valid, rsp_ready          : FIFO pop handshake
//   fifo_level                    : FIFO occupancy
//   overflow                      : one-cycle pulse on a dropped byte
module i2c_rx_fifo_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read_enable_pattern_detector,
    input  logic                          read_enable_controller,
    input  logic                          SCL_in,
    input  logic                          SDA_in,
    input  logic                          error,
    output logic                          SDA_out,
    output logic [DATA_WIDTH-1:0]         controller_data_rsp,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK_SETUP,
        ACK_HOLD
    } state_t;

    logic scl_s;
    logic sda_s;

`ifdef I2C_RX_SYNC_EN
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SCL_in};
            sda_sync <= {sda_sync[0], SDA_in};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`else
    assign scl_s = SCL_in;
    assign sda_s = SDA_in;
`endif

    // Idle bus is high, so the delayed copy resets to 1 to avoid a
    // spurious rise right after reset.
    logic scl_prev;
    logic scl_rise;
    logic scl_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
        end
    end

    assign scl_rise = ~scl_prev & scl_s;
    assign scl_fall = scl_prev & ~scl_s;

    logic read_enable;
    assign read_enable = read_enable_pattern_detector | read_enable_controller;

    state_t                  state;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-2:0]   shreg;
    logic                    nack;
    logic                    seen_rise;

    logic [DATA_WIDTH-1:0]   byte_done;
    logic                    last_bit;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    full;
    logic                    empty;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    assign byte_done = {shreg, sda_s};
    assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));

    assign push_req = (state == SHIFT) & read_enable & scl_rise & last_bit;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign pop = rsp_ready & ~empty;

    // A pop in the same cycle frees the slot the push is about to take.
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            nack      <= 1'b0;
            seen_rise <= 1'b0;
            SDA_out   <= 1'b1;
        end else if (state != IDLE && !read_enable) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            seen_rise <= 1'b0;
            SDA_out   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (read_enable) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (scl_rise) begin
                        shreg   <= byte_done[DATA_WIDTH-2:0];
                        bit_cnt <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            nack  <= error | ~push_ok;
                            state <= ACK_SETUP;
                        end
                    end
                end
                ACK_SETUP: begin
                    if (scl_fall) begin
                        if (read_enable_pattern_detector) begin
                            SDA_out <= nack | error;
                        end else begin
                            SDA_out <= 1'b1;
                        end
                        nack      <= nack | error;
                        seen_rise <= 1'b0;
                        state     <= ACK_HOLD;
                    end else if (error) begin
                        nack <= 1'b1;
                    end
                end
                ACK_HOLD: begin
                    // The fall that ends the ACK slot only counts after
                    // the 9th rise has been seen.
                    if (scl_rise) begin
                        seen_rise <= 1'b1;
                    end
                    if (scl_fall && seen_rise) begin
                        SDA_out   <= 1'b1;
                        bit_cnt   <= '0;
                        seen_rise <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= byte_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            overflow <= push_req & ~push_ok;
        end
    end

    assign rsp_valid           = ~empty;
    assign fifo_level          = wr_ptr - rd_ptr;
    assign controller_data_rsp = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_i2c_rx_fifo_receiver.sv
// Bench for i2c_rx_fifo_receiver: directed cases plus randomized bytes
// checked against a queue-based model of the receive FIFO.
module tb_i2c_rx_fifo_receiver;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          re_pd;
    logic          re_ctl;
    logic          SCL_in;
    logic          SDA_in;
    logic          error;
    logic          SDA_out;
    logic [DW-1:0] data_rsp;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    fifo_level;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int low_cnt;
    logic [7:0] q[$];

    i2c_rx_fifo_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .read_enable_pattern_detector (re_pd),
        .read_enable_controller       (re_ctl),
        .SCL_in                       (SCL_in),
        .SDA_in                       (SDA_in),
        .error                        (error),
        .SDA_out                      (SDA_out),
        .controller_data_rsp          (data_rsp),
        .rsp_valid                    (rsp_valid),
        .rsp_ready                    (rsp_ready),
        .fifo_level                   (fifo_level),
        .overflow                     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (overflow) ovf_cnt <= ovf_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (SDA_out === 1'b0) low_cnt++;
        end
    endtask

    task automatic start(input bit pd);
        re_pd  = 1'b0;
        re_ctl = 1'b0;
        SCL_in = 1'b1;
        step(2);
        re_pd  = pd;
        re_ctl = ~pd;
        step(2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n,
                             input bit err);
        for (int i = 7; i > 7 - n; i--) begin
            SCL_in = 1'b0;
            step(2);
            SDA_in = b[i];
            step(2);
            SCL_in = 1'b1;
            if (i == 0 && err) error = 1'b1;
            step(4);
        end
    endtask

    // Full byte plus ACK slot; reports ACK seen mid 9th high phase.
    task automatic send_byte(input logic [7:0] b, input bit err,
                             output bit ack);
        low_cnt = 0;
        send_bits(b, 8, err);
        SCL_in = 1'b0;
        SDA_in = 1'b1;
        step(4);
        SCL_in = 1'b1;
        step(2);
        ack = (SDA_out == 1'b0);
        step(2);
        SCL_in = 1'b0;
        error  = 1'b0;
        step(2);
    endtask

    // Model-driven byte: FIFO accepts while it has room.
    task automatic model_byte(input string tag, input logic [7:0] b,
                              input bit pd, input bit err);
        bit ack;
        bit acc;
        int ovf0;
        acc  = (q.size() < DEPTH);
        ovf0 = ovf_cnt;
        send_byte(b, err, ack);
        if (acc) q.push_back(b);
        check({tag, "_ack"}, 32'(ack), 32'(pd && !err && acc));
        check({tag, "_lowcyc"}, low_cnt, (pd && !err && acc) ? 8 : 0);
        check({tag, "_rel"}, 32'(SDA_out), 32'd1);
        check({tag, "_ovf"}, ovf_cnt - ovf0, acc ? 0 : 1);
        check({tag, "_lvl"}, 32'(fifo_level), q.size());
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
            check({tag, "_dat"}, 32'(data_rsp), 32'(q[0]));
            rsp_ready = 1'b1;
            step(1);
            rsp_ready = 1'b0;
            void'(q.pop_front());
        end
        check({tag, "_lvl"}, 32'(fifo_level), q.size());
    endtask

    task automatic drain_all(input string tag);
        drain(tag, DEPTH);
        rsp_ready = 1'b1;
        step(2);
        rsp_ready = 1'b0;
        check({tag, "_empty_lvl"}, 32'(fifo_level), 32'd0);
        check({tag, "_empty_vld"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit ack;
        bit pd;
        bit err;
        logic [7:0] b;

        rst = 1'b1;
        re_pd = 1'b0;
        re_ctl = 1'b0;
        SCL_in = 1'b1;
        SDA_in = 1'b1;
        error = 1'b0;
        rsp_ready = 1'b0;
        low_cnt = 0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_lvl", 32'(fifo_level), 32'd0);
        check("rst_sda", 32'(SDA_out), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dat", 32'(data_rsp), 32'd0);

        start(1'b1);
        model_byte("a5", 8'hA5, 1'b1, 1'b0);
        check("a5_dat", 32'(data_rsp), 32'hA5);
        check("a5_vld", 32'(rsp_valid), 32'd1);
        drain_all("a5_drain");

        start(1'b1);
        for (int i = 1; i <= 5; i++) begin
            model_byte("burst", 8'(i), 1'b1, 1'b0);
        end
        check("burst_lvl4", 32'(fifo_level), 32'd4);
        drain_all("burst_drain");

        start(1'b1);
        model_byte("err3c", 8'h3C, 1'b1, 1'b1);
        check("err3c_lvl1", 32'(fifo_level), 32'd1);

        start(1'b0);
        model_byte("ctlff", 8'hFF, 1'b0, 1'b0);

        start(1'b1);
        send_bits(8'hD7, 5, 1'b0);
        re_pd = 1'b0;
        step(3);
        check("abort_sda", 32'(SDA_out), 32'd1);
        check("abort_lvl", 32'(fifo_level), q.size());
        start(1'b1);
        model_byte("after_abort", 8'h81, 1'b1, 1'b0);
        drain_all("abort_drain");

        start(1'b1);
        model_byte("pre_rst0", 8'h11, 1'b1, 1'b0);
        model_byte("pre_rst1", 8'h22, 1'b1, 1'b0);
        send_bits(8'h96, 4, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        re_pd = 1'b0;
        q.delete();
        check("mrst_vld", 32'(rsp_valid), 32'd0);
        check("mrst_lvl", 32'(fifo_level), 32'd0);
        check("mrst_sda", 32'(SDA_out), 32'd1);
        step(2);
        start(1'b1);
        model_byte("post_rst", 8'h5A, 1'b1, 1'b0);
        drain_all("post_rst_drain");

        for (int it = 0; it < 60; it++) begin
            b   = 8'($urandom);
            pd  = ($urandom_range(0, 3) != 0);
            err = ($urandom_range(0, 5) == 0);
            start(pd);
            model_byte("rnd", b, pd, err);
            if ($urandom_range(0, 2) == 0) begin
                drain("rnd_drain", $urandom_range(1, DEPTH));
            end
        end
        drain_all("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
